loop_decode: RTL

Instruction fetch/decode front end for one ECC core's program sequencer. It drives the sequencer's `enable`, samples the 16-bit word returned by the synchronous instruction ROM for the sequencer's current `addr`, and decodes that word. LOOP words are turned into the one-cycle `loop_enable` pulse with `cnt1`/`cnt2` operands. All other opcodes are forwarded to the datapath. It tracks loop progress itself so that it never issues a second loop command while a loop is active, and it stops the core on HALT.

---
 rtl/ecc_isa_pkg.sv | 53 +++++
 rtl/loop_decode_if.sv | 40 ++++
 rtl/loop_tracker.sv | 48 ++++
 rtl/loop_decode.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ecc_isa_pkg.sv
// Shared ISA definitions for the ECC core program sequencer front end:
// word layout, opcode constants, word classification and FSM state encoding.
package ecc_isa_pkg;

  localparam int OPW   = 4;
  localparam int ARGW  = 12;
  localparam int WORDW = OPW + ARGW;
  localparam int CNT1W = 8;
  localparam int CNT2W = 4;

  // Field positions inside a 16-bit instruction word
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int ARG_MSB  = 11;
  localparam int ARG_LSB  = 0;
  localparam int CNT1_MSB = 11;
  localparam int CNT1_LSB = 4;
  localparam int CNT2_MSB = 3;
  localparam int CNT2_LSB = 0;

  localparam logic [OPW-1:0] OP_NOP     = 4'h0;
  localparam logic [OPW-1:0] OP_LOOP    = 4'h1;
  localparam logic [OPW-1:0] OP_ALU_MIN = 4'h2;
  localparam logic [OPW-1:0] OP_ALU_MAX = 4'hE;
  localparam logic [OPW-1:0] OP_HALT    = 4'hF;

  typedef enum logic [1:0] {
    W_NOP,
    W_LOOP,
    W_ALU,
    W_HALT
  } word_class_t;

  // One-hot state encoding
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_FILL = 5'b00010,
    S_RUN  = 5'b00100,
    S_LOOP = 5'b01000,
    S_HALT = 5'b10000
  } state_t;

  function automatic word_class_t classify(input logic [OPW-1:0] op);
    word_class_t c;
    c = W_NOP;
    if (op == OP_LOOP) c = W_LOOP;
    else if (op == OP_HALT) c = W_HALT;
    else if ((op >= OP_ALU_MIN) && (op <= OP_ALU_MAX)) c = W_ALU;
    else if (op == OP_NOP) c = W_NOP;
    return c;
  endfunction

endpackage

// File: rtl/loop_decode_if.sv
// Bundle between the fetch/decode front end and its surroundings
// (sequencer, ROM, datapath).
//
// Handshake: there is no back-pressure. op_valid and loop_enable are
// one-cycle strobes; their payloads (op_code/op_arg, cnt1/cnt2) are only
// meaningful in the cycle the strobe is high and must be taken then.
// enable, busy, done and err are levels. start is a level sampled only
// while the front end is idle or halted.
interface loop_decode_if;
  import ecc_isa_pkg::*;

  logic                   start;
  logic [WORDW-1:0]       rom_data;
  logic                   enable;
  logic                   loop_enable;
  logic [CNT1W-1:0]       cnt1;
  logic [CNT2W-1:0]       cnt2;
  logic                   op_valid;
  logic [OPW-1:0]         op_code;
  logic [ARGW-1:0]        op_arg;
  logic                   busy;
  logic                   done;
  logic                   err;
  state_t                 state_dbg;

  // Front end side
  modport master (
    input  start, rom_data,
    output enable, loop_enable, cnt1, cnt2, op_valid, op_code, op_arg,
           busy, done, err, state_dbg
  );

  // Environment side (sequencer, ROM, datapath)
  modport slave (
    output start, rom_data,
    input  enable, loop_enable, cnt1, cnt2, op_valid, op_code, op_arg,
           busy, done, err, state_dbg
  );

endinterface

// File: rtl/loop_tracker.sv
// Loop progress tracker: holds iteration and body counters for the active
// loop and flags the final body word (the sequencer's loop_done cycle).
module loop_tracker
  import ecc_isa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             flush,
  input  logic [CNT1W-1:0] cnt1,
  input  logic [CNT2W-1:0] cnt2,
  output logic             loop_exit
);

  logic [CNT1W-1:0] iter_cnt;
  logic [CNT2W-1:0] body_cnt;
  logic [CNT2W-1:0] body_reload;

  // Load on a new loop, clear on exit/halt, otherwise count one body word.
  // step is never asserted on the exit cycle, so iter_cnt only decrements
  // from 2 or more and body_cnt never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_cnt    <= '0;
      body_cnt    <= '0;
      body_reload <= '0;
    end else if (load) begin
      iter_cnt    <= cnt1;
      body_cnt    <= cnt2;
      body_reload <= cnt2;
    end else if (flush) begin
      iter_cnt    <= '0;
      body_cnt    <= '0;
      body_reload <= '0;
    end else if (step) begin
      if (body_cnt == '0) begin
        body_cnt <= body_reload;
        iter_cnt <= iter_cnt - 1'b1;
      end else begin
        body_cnt <= body_cnt - 1'b1;
      end
    end
  end

  assign loop_exit = (iter_cnt == CNT1W'(1)) && (body_cnt == '0);

endmodule

// File: rtl/loop_decode.sv
// Instruction fetch/decode front end: runs the sequencer, decodes ROM words
// into datapath micro-ops and single loop commands, and stops on HALT.
module loop_decode
  import ecc_isa_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  loop_decode_if.master bus
);

  state_t           state;
  logic             enable_q;
  logic             loop_enable_q;
  logic [CNT1W-1:0] cnt1_q;
  logic [CNT2W-1:0] cnt2_q;
  logic             op_valid_q;
  logic [OPW-1:0]   op_code_q;
  logic [ARGW-1:0]  op_arg_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [OPW-1:0]   word_op;
  logic [ARGW-1:0]  word_arg;
  logic [CNT1W-1:0] word_cnt1;
  logic [CNT2W-1:0] word_cnt2;
  word_class_t      word_class;
  logic             in_loop;
  logic             loop_load;
  logic             loop_flush;
  logic             loop_step;
  logic             loop_exit;

  assign word_op    = bus.rom_data[OP_MSB:OP_LSB];
  assign word_arg   = bus.rom_data[ARG_MSB:ARG_LSB];
  assign word_cnt1  = bus.rom_data[CNT1_MSB:CNT1_LSB];
  assign word_cnt2  = bus.rom_data[CNT2_MSB:CNT2_LSB];
  assign word_class = classify(word_op);

  // A loop is only accepted from RUN with a non-zero iteration count; the
  // tracker is cleared when the loop finishes or a HALT cuts it short.
  assign in_loop    = (state == S_LOOP);
  assign loop_load  = (state == S_RUN) && (word_class == W_LOOP) && (word_cnt1 != '0);
  assign loop_flush = in_loop && ((word_class == W_HALT) || loop_exit);
  assign loop_step  = in_loop && !loop_flush;

  loop_tracker u_tracker (
    .clk       (clk),
    .rst       (rst),
    .load      (loop_load),
    .step      (loop_step),
    .flush     (loop_flush),
    .cnt1      (word_cnt1),
    .cnt2      (word_cnt2),
    .loop_exit (loop_exit)
  );

  // Main FSM with registered decode outputs; strobes default low each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      enable_q      <= 1'b0;
      loop_enable_q <= 1'b0;
      cnt1_q        <= '0;
      cnt2_q        <= '0;
      op_valid_q    <= 1'b0;
      op_code_q     <= '0;
      op_arg_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      op_valid_q    <= 1'b0;
      loop_enable_q <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            state    <= S_FILL;
            enable_q <= 1'b1;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        S_FILL: begin
          // First ROM word is still in flight; nothing to decode yet.
          state <= S_RUN;
        end
        S_RUN, S_LOOP: begin
          if (word_class == W_HALT) begin
            state    <= S_HALT;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            if (word_class == W_ALU) begin
              op_valid_q <= 1'b1;
              op_code_q  <= word_op;
              op_arg_q   <= word_arg;
            end
            if (word_class == W_LOOP) begin
              if (loop_load) begin
                loop_enable_q <= 1'b1;
                cnt1_q        <= word_cnt1;
                cnt2_q        <= word_cnt2;
                state         <= S_LOOP;
              end else begin
                // Zero-count loop or nested loop: dropped and flagged.
                err_q <= 1'b1;
              end
            end
            if (in_loop && loop_exit) state <= S_RUN;
          end
        end
        default: begin
          state    <= S_IDLE;
          enable_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enable      = enable_q;
  assign bus.loop_enable = loop_enable_q;
  assign bus.cnt1        = cnt1_q;
  assign bus.cnt2        = cnt2_q;
  assign bus.op_valid    = op_valid_q;
  assign bus.op_code     = op_code_q;
  assign bus.op_arg      = op_arg_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.state_dbg   = state;

endmodule
